// File: rtl/frisc_arb_pkg.sv
// frisc_arb_pkg: shared sizes and types for the FRISC one-hot round-robin arbiter
package frisc_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W = 3;
  typedef logic [NUM_REQ-1:0] onehot_t;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/onehot_rr_pick.sv
// onehot_rr_pick: combinational round-robin winner selection from req starting at ptr
module onehot_rr_pick
  import frisc_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick_idx,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic               any_req
);
  logic [2*NUM_REQ-1:0] dbl;
  onehot_t rot;
  idx_t off;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];
  // lowest set bit of the rotated vector is the distance from ptr to the winner
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? idx_t'(i) : off;
  end
  assign any_req = |req;
  assign pick_idx = ptr + off;
  assign pick_oh = any_req ? onehot_t'(1) << pick_idx : '0;
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: 8-way round-robin arbiter feeding a single registered valid/ready output
module onehot_rr_arbiter
  import frisc_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]       in_ready,
  input  logic                     lock,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [NUM_REQ-1:0]       out_grant,
  output logic [IDX_W-1:0]         out_idx
);
  idx_t ptr;
  idx_t pick_idx;
  onehot_t pick_oh;
  logic any_req;
  logic can_load;
  logic xfer;
  onehot_rr_pick u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick_idx(pick_idx),
    .pick_oh (pick_oh),
    .any_req (any_req)
  );
  assign can_load = !out_valid || out_ready;
  assign in_ready = (can_load && any_req && !reset) ? pick_oh : '0;
  assign xfer = can_load && any_req;
  // load the winner on a transfer, otherwise empty the register once it is consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      out_idx   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[pick_idx*WIDTH +: WIDTH];
      out_grant <= pick_oh;
      out_idx   <= pick_idx;
      ptr       <= lock ? pick_idx : pick_idx + idx_t'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_grant <= '0;
      out_idx   <= '0;
    end
  end
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: scoreboard bench comparing the arbiter against a round-robin reference model
module tb_onehot_rr_arbiter;
  typedef struct {
    logic [31:0] d;
    int idx;
  } item_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] req = '0;
  logic [255:0] in_data = '0;
  logic [7:0] in_ready;
  logic lock = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0] out_grant;
  logic [2:0] out_idx;
  int checks = 0;
  int errors = 0;
  item_t q[$];
  int m_ptr = 0;
  bit m_full = 0;
  bit mon_en = 0;
  bit force4 = 0;
  logic [7:0] exp_ready = '0;
  logic exp_valid = 1'b0;

  onehot_rr_arbiter #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .in_data  (in_data),
    .in_ready (in_ready),
    .lock     (lock),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_grant(out_grant),
    .out_idx  (out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: first requester at or after the pointer, scanning circularly
  task automatic model();
    bit can;
    int pick;
    exp_valid = m_full;
    can = !m_full || out_ready;
    exp_ready = '0;
    pick = -1;
    for (int k = 0; k < 8; k++) begin
      if (pick < 0 && req[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
    end
    if (can && pick >= 0) begin
      item_t it;
      exp_ready[pick] = 1'b1;
      it.d = in_data[pick*32 +: 32];
      it.idx = pick;
      q.push_back(it);
      m_ptr = lock ? pick : (pick + 1) % 8;
      m_full = 1;
    end else if (can) begin
      m_full = 0;
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rdy, input logic lk);
    @(posedge clk);
    #2;
    req = r;
    out_ready = rdy;
    lock = lk;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom;
    if (force4) in_data[4*32 +: 32] = 32'hDEAD_BEEF;
    model();
  endtask

  task automatic reset_model();
    q.delete();
    m_ptr = 0;
    m_full = 0;
    exp_valid = 1'b0;
    exp_ready = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("grant_onehot0", 64'($onehot0(out_grant)), 64'd1);
      chk("ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 64'(out_valid), 64'd0);
        end else begin
          chk("out_data", 64'(out_data), 64'(q[0].d));
          chk("out_idx", 64'(out_idx), 64'(q[0].idx));
          chk("out_grant", 64'(out_grant), 64'(1) << q[0].idx);
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("empty_grant", 64'(out_grant), 64'd0);
        chk("empty_idx", 64'(out_idx), 64'd0);
      end
    end
  end

  initial begin
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    reset_model();
    mon_en = 1;
    force4 = 1;
    step(8'h10, 1, 0);
    force4 = 0;
    step(8'h21, 1, 0);
    step(8'h00, 1, 0);
    step(8'h80, 1, 0);
    for (int i = 0; i < 10; i++) step(8'hFF, 1, 0);
    step(8'h03, 1, 0);
    for (int i = 0; i < 5; i++) step(8'h03, 0, 0);
    step(8'h03, 1, 0);
    step(8'h03, 1, 0);
    step(8'h80, 1, 0);
    for (int i = 0; i < 3; i++) step(8'h05, 1, 1);
    step(8'h05, 1, 0);
    step(8'h05, 1, 0);
    step(8'h01, 1, 0);
    step(8'h00, 1, 0);
    step(8'h00, 1, 0);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      step(r, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);
    end
    step(8'h03, 1, 0);
    step(8'h03, 0, 0);
    @(posedge clk);
    #2;
    mon_en = 0;
    out_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_grant", 64'(out_grant), 64'd0);
    chk("async_rst_idx", 64'(out_idx), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    req = '0;
    reset = 1'b0;
    reset_model();
    mon_en = 1;
    step(8'hFF, 1, 0);
    step(8'hFF, 1, 0);
    step(8'h00, 1, 0);
    step(8'h00, 1, 0);
    @(posedge clk);
    #2;
    mon_en = 0;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
